// File: rtl/bcd_updown_counter_n.sv
// Parametrised N-digit BCD up/down counter with parallel load, wrap/saturate mode,
// registered boundary pulse and zero flag. Optional programmable up-boundary: BCD_CNT_LIMIT_EN.
`timescale 1ns/1ps

module bcd_updown_counter_n #(
   parameter int unsigned NDIGITS  = 4,
   parameter int unsigned SATURATE = 0
) (
   input  logic                 Clk,
   input  logic                 nReset,
   input  logic                 CntEn,
   input  logic                 UnD,
   input  logic                 Load,
   input  logic [4*NDIGITS-1:0] LoadVal,
`ifdef BCD_CNT_LIMIT_EN
   input  logic [4*NDIGITS-1:0] Limit,
`endif
   output logic [4*NDIGITS-1:0] Cout,
   output logic                 TermEvt,
   output logic                 Zero
);

   localparam int unsigned W = 4 * NDIGITS;
   localparam logic [W-1:0] UMAX = {NDIGITS{4'h9}};

   logic [W-1:0] cnt_q, cnt_d;
   logic         term_q, term_d;
   logic [W-1:0] cnt_clamp;
   logic [W-1:0] load_clamp;
   logic [W-1:0] cnt_inc;
   logic [W-1:0] cnt_dec;
   logic [W-1:0] up_bound_val;
   logic         at_up_bound;
   logic         at_zero;

   // Digits above 9 are treated as 9, both for arithmetic and on load.
   always_comb begin
      logic [3:0] d;
      logic [3:0] l;
      cnt_clamp  = '0;
      load_clamp = '0;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         d = cnt_q[4*i +: 4];
         l = LoadVal[4*i +: 4];
         cnt_clamp[4*i +: 4]  = (d > 4'd9) ? 4'd9 : d;
         load_clamp[4*i +: 4] = (l > 4'd9) ? 4'd9 : l;
      end
   end

   // Ripple decade carry: a digit steps only when every lower digit rolled over.
   always_comb begin
      logic [3:0] d;
      logic       carry;
      cnt_inc = '0;
      carry   = 1'b1;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         d = cnt_clamp[4*i +: 4];
         if (carry) begin
            if (d == 4'd9) begin
               cnt_inc[4*i +: 4] = 4'd0;
            end else begin
               cnt_inc[4*i +: 4] = d + 4'd1;
               carry             = 1'b0;
            end
         end else begin
            cnt_inc[4*i +: 4] = d;
         end
      end
   end

   always_comb begin
      logic [3:0] d;
      logic       borrow;
      cnt_dec = '0;
      borrow  = 1'b1;
      for (int i = 0; i < int'(NDIGITS); i++) begin
         d = cnt_clamp[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               cnt_dec[4*i +: 4] = 4'd9;
            end else begin
               cnt_dec[4*i +: 4] = d - 4'd1;
               borrow            = 1'b0;
            end
         end else begin
            cnt_dec[4*i +: 4] = d;
         end
      end
   end

   assign at_zero = (cnt_q == '0);

`ifdef BCD_CNT_LIMIT_EN
   // A loaded value above Limit counts as already at the boundary.
   assign up_bound_val = Limit;
   assign at_up_bound  = (cnt_q >= Limit);
`else
   assign up_bound_val = UMAX;
   assign at_up_bound  = (cnt_clamp == UMAX);
`endif

   always_comb begin
      cnt_d  = cnt_q;
      term_d = 1'b0;
      if (Load) begin
         cnt_d = load_clamp;
      end else if (CntEn) begin
         if (UnD) begin
            if (at_up_bound) begin
               term_d = 1'b1;
               cnt_d  = (SATURATE != 0) ? up_bound_val : '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end else begin
            if (at_zero) begin
               term_d = 1'b1;
               cnt_d  = (SATURATE != 0) ? '0 : up_bound_val;
            end else begin
               cnt_d = cnt_dec;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         cnt_q  <= '0;
         term_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= term_d;
      end
   end

   assign Cout    = cnt_q;
   assign TermEvt = term_q;
   assign Zero    = at_zero;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for bcd_updown_counter_n: wrap and saturate instances side by side,
// plus a 2-digit Limit instance when BCD_CNT_LIMIT_EN is defined.
`timescale 1ns/1ps

module tb_bcd_updown_counter_n;

   localparam int unsigned ND = 4;
   localparam int unsigned W  = 4 * ND;

   logic         Clk = 1'b0;
   logic         nReset;
   logic         CntEn;
   logic         UnD;
   logic         Load;
   logic [W-1:0] LoadVal;

   logic [W-1:0] cout_w, cout_s;
   logic         term_w, term_s, zero_w, zero_s;

`ifdef BCD_CNT_LIMIT_EN
   localparam int NINST = 3;
   logic [W-1:0] limit_main = 16'h9999;
   logic [7:0]   limit_l    = 8'h59;
   logic [7:0]   cout_l;
   logic         term_l, zero_l;
`else
   localparam int NINST = 2;
`endif

   always #5 Clk = ~Clk;

   bcd_updown_counter_n #(.NDIGITS(ND), .SATURATE(0)) dut_wrap (
      .Clk(Clk), .nReset(nReset), .CntEn(CntEn), .UnD(UnD), .Load(Load), .LoadVal(LoadVal),
`ifdef BCD_CNT_LIMIT_EN
      .Limit(limit_main),
`endif
      .Cout(cout_w), .TermEvt(term_w), .Zero(zero_w)
   );

   bcd_updown_counter_n #(.NDIGITS(ND), .SATURATE(1)) dut_sat (
      .Clk(Clk), .nReset(nReset), .CntEn(CntEn), .UnD(UnD), .Load(Load), .LoadVal(LoadVal),
`ifdef BCD_CNT_LIMIT_EN
      .Limit(limit_main),
`endif
      .Cout(cout_s), .TermEvt(term_s), .Zero(zero_s)
   );

`ifdef BCD_CNT_LIMIT_EN
   bcd_updown_counter_n #(.NDIGITS(2), .SATURATE(0)) dut_lim (
      .Clk(Clk), .nReset(nReset), .CntEn(CntEn), .UnD(UnD), .Load(Load),
      .LoadVal(LoadVal[7:0]), .Limit(limit_l),
      .Cout(cout_l), .TermEvt(term_l), .Zero(zero_l)
   );
`endif

   typedef struct {
      string        tag;
      int           inst;
      logic [W-1:0] cout;
      logic         term;
      logic         zero;
   } exp_t;

   exp_t sb[$];

   // Decimal reference model, one slot per instance: wrap, saturate, limit.
   int mval [3];
   bit mterm[3];
   int mmax [3] = '{9999, 9999, 59};
   int mnd  [3] = '{4, 4, 2};
   bit msat [3] = '{1'b0, 1'b1, 1'b0};

   int checks = 0;
   int errors = 0;

   function automatic logic [W-1:0] to_bcd(int v);
      logic [W-1:0] r;
      int           t;
      r = '0;
      t = v;
      for (int i = 0; i < int'(ND); i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   function automatic int load_int(logic [W-1:0] lv, int nd);
      int v;
      int p;
      int d;
      v = 0;
      p = 1;
      for (int i = 0; i < nd; i++) begin
         d = int'(lv[4*i +: 4]);
         if (d > 9) d = 9;
         v = v + d * p;
         p = p * 10;
      end
      return v;
   endfunction

   task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_entry(string tag, int k);
      exp_t e;
      e.tag  = tag;
      e.inst = k;
      e.cout = to_bcd(mval[k]);
      e.term = mterm[k];
      e.zero = (mval[k] == 0);
      sb.push_back(e);
   endtask

   // Advance the model with the inputs now being driven and queue the results.
   task automatic push_step(string tag);
      for (int k = 0; k < NINST; k++) begin
         if (Load) begin
            mval[k]  = load_int(LoadVal, mnd[k]);
            mterm[k] = 1'b0;
         end else if (CntEn && UnD) begin
            mterm[k] = (mval[k] >= mmax[k]);
            if (mterm[k]) mval[k] = msat[k] ? mmax[k] : 0;
            else          mval[k] = mval[k] + 1;
         end else if (CntEn) begin
            mterm[k] = (mval[k] == 0);
            if (mterm[k]) mval[k] = msat[k] ? 0 : mmax[k];
            else          mval[k] = mval[k] - 1;
         end else begin
            mterm[k] = 1'b0;
         end
         push_entry(tag, k);
      end
   endtask

   task automatic push_reset(string tag);
      for (int k = 0; k < NINST; k++) begin
         mval[k]  = 0;
         mterm[k] = 1'b0;
         push_entry(tag, k);
      end
   endtask

   task automatic pop_all();
      exp_t         e;
      logic [W-1:0] oc;
      logic         ot, oz;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.inst)
            0:       begin oc = cout_w; ot = term_w; oz = zero_w; end
            1:       begin oc = cout_s; ot = term_s; oz = zero_s; end
`ifdef BCD_CNT_LIMIT_EN
            2:       begin oc = W'(cout_l); ot = term_l; oz = zero_l; end
`endif
            default: begin oc = 'x; ot = 1'bx; oz = 1'bx; end
         endcase
         check($sformatf("%s/i%0d/cout", e.tag, e.inst), oc, e.cout);
         check($sformatf("%s/i%0d/term", e.tag, e.inst), W'(ot), W'(e.term));
         check($sformatf("%s/i%0d/zero", e.tag, e.inst), W'(oz), W'(e.zero));
      end
   endtask

   task automatic step(string tag, logic ld, logic en, logic up, logic [W-1:0] lv);
      @(negedge Clk);
      Load    = ld;
      CntEn   = en;
      UnD     = up;
      LoadVal = lv;
      push_step(tag);
      @(posedge Clk);
      #1;
      pop_all();
   endtask

   initial begin
      nReset  = 1'b0;
      CntEn   = 1'b0;
      UnD     = 1'b1;
      Load    = 1'b0;
      LoadVal = '0;
      #12;
      push_reset("reset");
      pop_all();
      @(negedge Clk);
      nReset = 1'b1;

      // Count to 0123, then reset between edges.
      step("ld0120", 1'b1, 1'b0, 1'b1, 16'h0120);
      for (int i = 0; i < 3; i++) step("up_to_0123", 1'b0, 1'b1, 1'b1, 16'h0000);
      @(posedge Clk);
      #2;
      nReset = 1'b0;
      #1;
      push_reset("async_rst");
      pop_all();
      @(negedge Clk);
      nReset = 1'b1;

      // Decade carry and borrow.
      step("ld0199",   1'b1, 1'b0, 1'b1, 16'h0199);
      step("up0199",   1'b0, 1'b1, 1'b1, 16'h0000);
      step("ld0200",   1'b1, 1'b0, 1'b1, 16'h0200);
      step("dn0200",   1'b0, 1'b1, 1'b0, 16'h0000);

      // Boundary up/down in both modes.
      step("ld9999",   1'b1, 1'b0, 1'b1, 16'h9999);
      step("up9999",   1'b0, 1'b1, 1'b1, 16'h0000);
      step("hold",     1'b0, 1'b0, 1'b1, 16'h0000);
      step("dn_bound", 1'b0, 1'b1, 1'b0, 16'h0000);
      step("ld9998",   1'b1, 1'b0, 1'b1, 16'h9998);
      for (int i = 0; i < 3; i++) step("sat_up", 1'b0, 1'b1, 1'b1, 16'h0000);
      step("ld0000",   1'b1, 1'b0, 1'b1, 16'h0000);
      step("dn0000",   1'b0, 1'b1, 1'b0, 16'h0000);
      step("dn0000b",  1'b0, 1'b1, 1'b0, 16'h0000);

      // Load wins over count and clamps illegal digits.
      step("ld_prio",  1'b1, 1'b1, 1'b1, 16'h3A7F);
      step("rev_dn",   1'b0, 1'b1, 1'b0, 16'h0000);
      step("rev_up",   1'b0, 1'b1, 1'b1, 16'h0000);

      // Limit boundary sequence for the 2-digit instance.
      step("ld0058",   1'b1, 1'b0, 1'b1, 16'h0058);
      step("up58",     1'b0, 1'b1, 1'b1, 16'h0000);
      step("up59",     1'b0, 1'b1, 1'b1, 16'h0000);
      step("dn00",     1'b0, 1'b1, 1'b0, 16'h0000);

      for (int i = 0; i < 60; i++) begin
         step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
